// File: rtl/button_debouncer.sv
// Button debouncer: synchronises a raw, bouncing button/switch level into the clk
// domain and only accepts a new level once it has been seen for STABLE_CYCLES
// consecutive synchronised samples. Feeds a rising-edge-to-pulse stage that
// needs exactly one clean 0->1 transition per physical press.
//
// Parameters:
//   SYNC_STAGES   - synchroniser depth (>= 2)
//   STABLE_CYCLES - consecutive samples needed to accept a new level (>= 1)
// Ports:
//   clk      - clock, all logic in this domain
//   reset    - asynchronous active-low reset (release already synchronised)
//   data_in  - raw asynchronous button level
//   data_out - debounced level
//   settling - high while a candidate level change is being timed
module button_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic data_out,
  output logic settling
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  // With a one-sample threshold the first differing sample is accepted at once,
  // so the counter must stay at zero to respect its STABLE_CYCLES-1 ceiling.
  localparam logic [CntW-1:0] CntFirst = (STABLE_CYCLES == 1) ? '0 : CntW'(1);

  // Encoding chosen so data_out and settling are state flop bits directly.
  typedef enum logic [1:0] {
    StStable0  = 2'b00,
    StPending1 = 2'b01,
    StStable1  = 2'b10,
    StPending0 = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  // Synchroniser chain; nothing else touches data_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StStable0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStable0: begin
        if (s) begin
          cnt_d   = CntFirst;
          state_d = (STABLE_CYCLES == 1) ? StStable1 : StPending1;
        end else begin
          cnt_d = '0;
        end
      end
      StPending1: begin
        if (s) begin
          if (cnt_q == CntLast) begin
            state_d = StStable1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          // Glitch rejected; no partial credit kept.
          state_d = StStable0;
          cnt_d   = '0;
        end
      end
      StStable1: begin
        if (!s) begin
          cnt_d   = CntFirst;
          state_d = (STABLE_CYCLES == 1) ? StStable0 : StPending0;
        end else begin
          cnt_d = '0;
        end
      end
      StPending0: begin
        if (!s) begin
          if (cnt_q == CntLast) begin
            state_d = StStable0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          state_d = StStable1;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign data_out = state_q[1];
  assign settling = state_q[0];

endmodule
